pipe_register: RTL and testbench

Parametrised pipeline register, the successor to the fixed 32-bit edge-triggered data register. It is a chain of `STAGES` registers of `WIDTH` bits with a valid/ready handshake, per-stage bubble collapsing, and an occupancy count. It sits between datapath blocks wherever a timing cut with backpressure is needed.

---
 rtl/pipe_register_pkg.sv | 24 ++
 rtl/pipe_register_stage.sv | 68 ++++++
 rtl/pipe_register.sv | 125 ++++++++++++
 tb/tb_pipe_register.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_register_pkg.sv
// -----------------------------------------------------------------------------
// pipe_register_pkg
// Shared helpers for the pipe_register block:
//   occ_w()         width of the occupancy count for a given number of stages
//   width_ok()      legality of the WIDTH parameter
//   stages_ok()     legality of the STAGES parameter
// No ports; imported by pipe_register and pipe_register_stage.
// -----------------------------------------------------------------------------
package pipe_register_pkg;

    // Enough bits to count 0..stages inclusive.
    function automatic int unsigned occ_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return width >= 1;
    endfunction

    function automatic bit stages_ok(input int unsigned stages);
        return stages >= 1;
    endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// -----------------------------------------------------------------------------
// pipe_register_stage
// One stage of the pipe_register chain: a data register, a valid flag, the
// load enable and the local ready term.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset, clears valid and data
//   clear      drops the valid flag (flush); data is left untouched
//   up_valid   valid of the upstream stage (or in_valid for stage 0)
//   up_data    data of the upstream stage (or d for stage 0)
//   down_rdy   ready of the downstream stage (or out_ready for the last stage)
//   valid      this stage holds a word
//   data       word held by this stage
//   rdy        this stage can take a word this cycle
//   valid_nxt  value valid takes at the next edge (feeds the occupancy count)
// -----------------------------------------------------------------------------
module pipe_register_stage
    import pipe_register_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy,
    output logic             valid_nxt
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             load;

    always_comb begin
        // An empty stage always accepts, which is what collapses bubbles.
        rdy  = ~valid_q | down_rdy;
        load = rdy & up_valid & ~clear;

        valid_nxt = valid_q;
        if (reset || clear) begin
            valid_nxt = 1'b0;
        end else if (rdy) begin
            valid_nxt = up_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_nxt;
            // Data only moves with a real word; an empty stage keeps its last value.
            if (load) begin
                data_q <= up_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_register.sv
// -----------------------------------------------------------------------------
// pipe_register
// Parametrised pipeline register: STAGES registers of WIDTH bits with a
// valid/ready handshake, per-stage bubble collapsing and a registered
// occupancy count. The ready chain is fully combinational (no skid stage).
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   STAGES     number of register stages (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset; discards all held words
//   in_valid   upstream presents a word on d
//   in_ready   stage 0 can accept a word this cycle
//   d          input data
//   flush      drop all held words (only with PIPE_REGISTER_FLUSH_EN)
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts q this cycle
//   q          data register of the last stage
//   occupancy  number of valid stages
//
// Build option:
//   PIPE_REGISTER_FLUSH_EN  adds the flush port; otherwise flush is tied off.
// -----------------------------------------------------------------------------
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    localparam int unsigned OCC_W = occ_w(STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
`ifdef PIPE_REGISTER_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [OCC_W-1:0] occupancy
);

    if (!width_ok(WIDTH) || !stages_ok(STAGES)) begin : g_bad_params
        $error("pipe_register: WIDTH and STAGES must both be at least 1");
    end

`ifndef PIPE_REGISTER_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    logic [STAGES-1:0] valid_nxt;
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_q;

    // Each stage links to its neighbours through per-block signals so the
    // ready chain runs from out_ready back to stage 0 without a shared vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_rdy;
        logic             stage_valid;
        logic [WIDTH-1:0] stage_data;
        logic             stage_rdy;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = d;
        end else begin : g_link
            assign up_valid = g_stage[i-1].stage_valid;
            assign up_data  = g_stage[i-1].stage_data;
        end

        if (i == STAGES - 1) begin : g_tail
            assign down_rdy = out_ready;
        end else begin : g_mid
            assign down_rdy = g_stage[i+1].stage_rdy;
        end

        pipe_register_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush),
            .up_valid  (up_valid),
            .up_data   (up_data),
            .down_rdy  (down_rdy),
            .valid     (stage_valid),
            .data      (stage_data),
            .rdy       (stage_rdy),
            .valid_nxt (valid_nxt[i])
        );
    end

    // Reset empties every stage, so in_ready is reported high while it is
    // asserted; a flush cycle blocks both ends so nothing transfers.
    assign in_ready  = reset | (g_stage[0].stage_rdy & ~flush);
    assign out_valid = g_stage[STAGES-1].stage_valid & ~flush;
    assign q         = g_stage[STAGES-1].stage_data;

    // Count the valids the stages will hold after this edge, so the
    // registered count lines up with the registered valid flags.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_register.sv
// -----------------------------------------------------------------------------
// tb_pipe_register
// Self-checking bench for pipe_register (WIDTH=32, STAGES=3). A reference
// model keeps the held words as a queue, each tagged with its stage position.
// -----------------------------------------------------------------------------
module tb_pipe_register;

    localparam int W = 32;
    localparam int S = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  d;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  q;
    logic [1:0]    occupancy;
    logic          flush;

    pipe_register #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
`ifdef PIPE_REGISTER_FLUSH_EN
        .flush     (flush),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: oldest word at index 0, each with its stage position.
    logic [W-1:0] m_data[$];
    int           m_pos[$];
    logic [W-1:0] m_q;
    bit           m_known = 1'b0;
    int           n_in = 0;
    int           n_out = 0;
    logic [W-1:0] out_log[$];

    // Values observed in the most recent cycle, for directed checks.
    logic         obs_in_ready;
    logic [1:0]   obs_occ;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic iv, input logic [W-1:0] dv,
                       input logic ordy, input logic fl);
        logic exp_in_ready;
        logic exp_out_valid;
        int   sz;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        d         = dv;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz = m_data.size();
        exp_out_valid = !fl && sz > 0 && m_pos[0] == S - 1;
        exp_in_ready  = rst || (!fl && (sz < S || ordy));
        obs_in_ready  = in_ready;
        obs_occ       = occupancy;
        chk("in_ready", in_ready, exp_in_ready);
        if (m_known) begin
            chk("out_valid", out_valid, exp_out_valid);
            chk("q", q, m_q);
            chk("occupancy", occupancy, sz);
        end
        @(posedge clk);
        if (rst) begin
            m_data.delete();
            m_pos.delete();
            m_q = '0;
            m_known = 1'b1;
        end else if (fl) begin
            m_data.delete();
            m_pos.delete();
        end else if (m_known) begin
            // A word moves on when there is a free slot somewhere ahead of it
            // or the output is draining this cycle.
            for (int i = 0; i < sz; i++) begin
                int p;
                p = m_pos[i];
                if (p < S - 1 && (i < S - 1 - p || ordy)) begin
                    m_pos[i] = p + 1;
                    if (p + 1 == S - 1) m_q = m_data[i];
                end
            end
            if (exp_out_valid && ordy) begin
                out_log.push_back(m_data[0]);
                void'(m_data.pop_front());
                void'(m_pos.pop_front());
                n_out++;
            end
            if (iv && exp_in_ready) begin
                m_data.push_back(dv);
                m_pos.push_back(0);
                n_in++;
            end
        end
    endtask

    initial begin
        int base_in;
        int base_out;
        reset = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_occ", obs_occ, 0);
        chk("rst_in_ready", obs_in_ready, 1);

        // Streaming
        out_log.delete();
        cyc(0, 1, 32'hABCDEF32, 1, 0);
        cyc(0, 1, 32'h12345678, 1, 0);
        cyc(0, 1, 32'h18EE0001, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        chk("stream_count", out_log.size(), 3);
        chk("stream_w0", out_log[0], 32'hABCDEF32);
        chk("stream_w2", out_log[2], 32'h18EE0001);

        // Backpressure
        out_log.delete();
        cyc(0, 1, 32'h9487D3C1, 0, 0);
        cyc(0, 1, 32'hA1B2C3D4, 0, 0);
        cyc(0, 1, 32'h006E442F, 0, 0);
        cyc(0, 1, 32'h1654FDD3, 0, 0);
        chk("bp_in_ready_4th", obs_in_ready, 0);
        chk("bp_occ", obs_occ, 3);
        cyc(0, 1, 32'h1654FDD3, 1, 0);
        chk("bp_4th_accepted", obs_in_ready, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        chk("bp_count", out_log.size(), 4);
        chk("bp_w3", out_log[3], 32'h1654FDD3);

        // Bubble collapse
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h1957AFCE, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h00000011, 0, 0);
        chk("bub_acc1", obs_in_ready, 1);
        cyc(0, 1, 32'h00000022, 0, 0);
        chk("bub_acc2", obs_in_ready, 1);
        cyc(0, 0, 0, 0, 0);
        chk("bub_occ", obs_occ, 3);

        // Reset mid-stream
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hCAFE0001, 0, 0);
        cyc(0, 1, 32'hCAFE0002, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("midrst_occ_before", obs_occ, 2);
        cyc(0, 0, 0, 0, 0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_q", q, 0);
        chk("midrst_in_ready", obs_in_ready, 1);

        // Full pass-through
        for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0, 0);
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, $urandom, 1, 0);
            chk("full_occ", obs_occ, 3);
        end
        chk("full_in_xfers", n_in - base_in, 5);
        chk("full_out_xfers", n_out - base_out, 5);

`ifdef PIPE_REGISTER_FLUSH_EN
        // Flush with a full pipe
        base_out = n_out;
        cyc(0, 1, 32'h0BADF00D, 0, 1);
        chk("flush_in_ready", obs_in_ready, 0);
        cyc(0, 0, 0, 1, 0);
        chk("flush_occ", obs_occ, 0);
        chk("flush_no_out", n_out - base_out, 0);
`endif

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic rst;
            logic fl;
            rst = ($urandom_range(0, 59) == 0);
            fl  = 1'b0;
`ifdef PIPE_REGISTER_FLUSH_EN
            fl  = ($urandom_range(0, 39) == 0);
`endif
            cyc(rst, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
